ascon_msg_packer: RTL and testbench
===================================

Name: ascon_msg_packer

Overview:
Byte-stream front end for the Ascon hash core. It accepts message bytes over a valid/ready handshake and packs them big-endian into 64-bit blocks. Each block is presented to the core with the core's 9-bit last-length code and a one-cycle start pulse per message. It sits between the external byte source and the hash core's block_in/last/start inputs.

Parameters:
BW, 64, block width in bits; fixed at 64 (8 bytes per block); other values are unsupported.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
s_valid  input  1  input byte valid
s_ready  output  1  packer can accept a byte this cycle
s_data  input  8  message byte
s_last  input  1  qualifies s_data as the final byte of the message
s_empty  input  1  with s_valid: zero-length message strobe; s_data and s_last ignored
m_valid  output  1  block_out/last_out valid
m_ready  input  1  core accepts the block
block_out  output  BW  packed block; first byte in [63:56]
last_out  output  9  one-hot valid-byte count of the final block; all zero for non-final blocks
start_out  output  1  one-cycle pulse marking a new message
busy  output  1  message in progress (state != IDLE)

Behaviour:
- Reset values (async, immediate): m_valid=0, block_out=0, last_out=0, start_out=0, busy=0, byte count=0, state=IDLE.
- States:
  - IDLE: no message in progress; s_ready=1.
  - FILL: accumulating bytes; s_ready=1.
  - HOLD: block presented; s_ready=0.
- Byte accept: a byte is accepted when s_valid && s_ready. Byte k of the block (k=0..7) is written to block_out[63-8k -: 8]; the byte count then increments.
- Byte-count bounds: count is 3 bits plus a full flag. Bytes not yet written are 0; the block register clears when a block is accepted by the core.
- start_out: registered. It is 1 in the cycle after the first accepted byte of a message (from IDLE), or after an accepted s_empty.
- IDLE→FILL on a byte accept without s_last. IDLE→HOLD on a byte accept with s_last (1-byte message) or on s_empty.
- FILL→HOLD when the 8th byte is accepted (last_out=0 unless s_last), or when s_last is accepted at count n.
- last_out encoding for a final block: last_out[n]=1, where n = valid bytes 1..8. An empty message gives last_out[0]=1 and block_out=0.
- Full final block: a message whose length is a multiple of 8 ends with a full block carrying last_out[8]=1. No extra padding block is emitted; padding is done in the core.
- HOLD: m_valid=1. block_out and last_out are held stable until m_valid && m_ready.
  - On accept of a final block: go to IDLE, clear the block register, count=0.
  - On accept of a non-final block: go to FILL, count=0.
- Throughput: 1 byte/cycle within a block. Each block costs one HOLD cycle minimum, so no byte is accepted in the m_ready cycle.
- Latency: m_valid rises the cycle after the completing byte is accepted.
- s_empty while in FILL: protocol error. It is ignored; no state change.
- s_last and s_empty both high in IDLE: s_empty wins.
- m_ready while m_valid=0: ignored.
- Reset asserted mid-message: the partial block is discarded and all outputs return to reset values asynchronously. No start_out or m_valid is produced on reset release.

Test Plan:
- Bytes 0x61,0x62,0x63 (s_last on 0x63), m_ready=1 → start_out pulse 1 cycle after 0x61; one block 0x6162630000000000 with last_out=9'b000001000; busy returns to 0.
- Bytes 0x00..0x07, s_last on 0x07 → one block 0x0001020304050607 with last_out=9'b100000000; exactly one m_valid handshake.
- 11 bytes 0x10..0x1A → first block 0x1011121314151617 with last_out=0; second block 0x18191A0000000000 with last_out=9'b000001000; start_out pulses once.
- s_empty strobe in IDLE → start_out pulse; block_out=0, last_out=9'b000000001; return to IDLE.
- Full block pending with m_ready held low for 5 cycles → s_ready=0, and block_out/last_out stable for all 5 cycles. m_ready=1 → one accept, then s_ready=1 the next cycle.
- 5 bytes accepted, then rstn low for 2 cycles mid-message → all outputs 0 immediately. A new 1-byte message 0xAA afterwards → block 0xAA00000000000000 with last_out=9'b000000010; no stale bytes.

Source files
------------

// File: rtl/ascon_msg_packer.sv
// ascon_msg_packer
//   Byte-stream front end for the Ascon hash core. Accepts message bytes over
//   a valid/ready handshake, packs them big-endian into 64-bit blocks and
//   presents each block with a one-hot last-length code and a one-cycle
//   start pulse per message.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   s_valid    input byte valid
//   s_ready    packer can accept a byte this cycle
//   s_data     message byte
//   s_last     s_data is the final byte of the message
//   s_empty    with s_valid: zero-length message strobe (s_data/s_last ignored)
//   m_valid    block_out/last_out valid
//   m_ready    core accepts the block
//   block_out  packed block, first byte in [63:56]
//   last_out   one-hot valid-byte count of the final block, zero otherwise
//   start_out  one-cycle pulse marking a new message
//   busy       message in progress
module ascon_msg_packer #(
    parameter int unsigned BW = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    input  logic          s_empty,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [BW-1:0] block_out,
    output logic [8:0]    last_out,
    output logic          start_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   block_q, block_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            full_q, full_d;
    logic [8:0]      last_q, last_d;
    logic            start_q, start_d;
    logic [3:0]      n_bytes;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            block_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            last_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            last_q  <= last_d;
            start_q <= start_d;
        end
    end

    // Valid-byte count of the block once the byte at cnt_q is written.
    assign n_bytes = {1'b0, cnt_q} + 4'd1;

    always_comb begin
        state_d = state_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        last_d  = last_q;
        start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    start_d = 1'b1;
                    block_d = '0;
                    if (s_empty) begin
                        // Zero-length message: empty block, last_out[0].
                        cnt_d   = '0;
                        last_d  = 9'b0_0000_0001;
                        state_d = HOLD;
                    end else begin
                        block_d[BW-1 -: 8] = s_data;
                        cnt_d = 3'd1;
                        if (s_last) begin
                            last_d  = 9'b0_0000_0010;
                            state_d = HOLD;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end

            FILL: begin
                // s_empty mid-message is a protocol error and is dropped.
                if (s_valid && !s_empty && !full_q) begin
                    for (int unsigned k = 0; k < BW / 8; k++) begin
                        if (cnt_q == k[2:0]) begin
                            block_d[BW - 1 - 8 * k -: 8] = s_data;
                        end
                    end
                    cnt_d  = cnt_q + 3'd1;
                    full_d = (cnt_q == 3'd7);
                    if (s_last) begin
                        last_d  = 9'(9'd1 << n_bytes);
                        state_d = HOLD;
                    end else if (cnt_q == 3'd7) begin
                        last_d  = '0;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (m_ready) begin
                    // The block register is cleared on every accept so that
                    // unwritten byte lanes of the next block read as zero.
                    block_d = '0;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    last_d  = '0;
                    state_d = (last_q != '0) ? IDLE : FILL;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready   = (state_q != HOLD) && !full_q;
    assign m_valid   = (state_q == HOLD);
    assign block_out = block_q;
    assign last_out  = last_q;
    assign start_out = start_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_msg_packer.sv
`timescale 1ns/1ps
module tb_ascon_msg_packer;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_empty;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] block_out;
    logic [8:0]  last_out;
    logic        start_out;
    logic        busy;

    ascon_msg_packer #(.BW(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_empty   (s_empty),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .block_out (block_out),
        .last_out  (last_out),
        .start_out (start_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] blk;
        logic [8:0]  lst;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  msg[$];
    int          checks   = 0;
    int          failures = 0;
    int          starts   = 0;
    int          hs       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: cut the message into 8-byte big-endian chunks; the
    // final chunk carries a one-hot length code, the empty message one block.
    task automatic model_msg();
        int unsigned n;
        int unsigned c;
        exp_t        e;
        n = msg.size();
        if (n == 0) begin
            e.blk = 64'h0;
            e.lst = 9'h001;
            expq.push_back(e);
        end else begin
            for (int unsigned i = 0; i < n; i += 8) begin
                c = (n - i < 8) ? (n - i) : 8;
                e.blk = 64'h0;
                for (int unsigned j = 0; j < c; j++)
                    e.blk = e.blk | (64'(msg[i + j]) << (56 - 8 * j));
                e.lst = (i + 8 >= n) ? 9'(1 << c) : 9'h000;
                expq.push_back(e);
            end
        end
    endtask

    // Compare process: every cycle the block is presented it must equal the
    // head of the expected queue; a handshake retires the head.
    always @(negedge clk) begin
        if (rstn) begin
            if (start_out) starts++;
            if (m_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_m_valid", 64'(m_valid), 64'd0);
                end else begin
                    chk("block_out", block_out, expq[0].blk);
                    chk("last_out", 64'(last_out), 64'(expq[0].lst));
                    if (m_ready) begin
                        void'(expq.pop_front());
                        hs++;
                    end
                end
            end
        end
    end

    // Holds s_valid until the DUT reports s_ready ahead of a rising edge.
    task automatic handshake();
        logic acc;
        int   tries;
        tries = 0;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            tries++;
            if (tries > 50) begin
                chk("s_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_empty = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_empty = 1'b0;
        handshake();
    endtask

    task automatic wait_drain();
        int tries;
        tries = 0;
        while (expq.size() != 0 || m_valid) begin
            @(posedge clk);
            #1;
            tries++;
            if (tries > 100) begin
                chk("drain_timeout", 64'(expq.size()), 64'd0);
                break;
            end
        end
    endtask

    task automatic drive_msg(input bit hold_test);
        int s0, h0, nexp, n;
        s0 = starts;
        h0 = hs;
        nexp = expq.size();
        n = msg.size();
        for (int i = 0; i < n; i++) begin
            send_byte(msg[i], i == n - 1);
            if (i == 0) chk("start_after_first", 64'(start_out), 64'd1);
        end
        chk("m_valid_latency", 64'(m_valid), 64'd1);
        if (hold_test) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("hold_s_ready", 64'(s_ready), 64'd0);
                chk("hold_block", block_out, 64'h0001020304050607);
                chk("hold_last", 64'(last_out), 64'h100);
            end
            @(posedge clk);
            #1;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            chk("post_accept_s_ready", 64'(s_ready), 64'd1);
            chk("post_accept_m_valid", 64'(m_valid), 64'd0);
        end
        wait_drain();
        chk("busy_idle", 64'(busy), 64'd0);
        chk("start_count", 64'(starts - s0), 64'd1);
        chk("handshake_count", 64'(hs - h0), 64'(nexp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        s_empty = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_block", block_out, 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_start", 64'(start_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        model_msg();
        chk("model_abc_blk", expq[0].blk, 64'h6162630000000000);
        chk("model_abc_lst", 64'(expq[0].lst), 64'h008);
        drive_msg(1'b0);

        // Exactly one full final block
        msg = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        model_msg();
        chk("model_full_lst", 64'(expq[0].lst), 64'h100);
        drive_msg(1'b0);

        // 11 bytes -> two blocks
        msg.delete();
        for (int i = 0; i < 11; i++) msg.push_back(8'(8'h10 + i));
        model_msg();
        chk("model_11_blk0", expq[0].blk, 64'h1011121314151617);
        chk("model_11_lst0", 64'(expq[0].lst), 64'h000);
        chk("model_11_blk1", expq[1].blk, 64'h18191A0000000000);
        chk("model_11_lst1", 64'(expq[1].lst), 64'h008);
        drive_msg(1'b0);

        // Empty message; s_last and junk data ride along and must be ignored
        begin
            int s0;
            s0 = starts;
            msg.delete();
            model_msg();
            s_valid = 1'b1;
            s_empty = 1'b1;
            s_last  = 1'b1;
            s_data  = 8'hFF;
            handshake();
            chk("empty_start", 64'(start_out), 64'd1);
            wait_drain();
            chk("empty_busy", 64'(busy), 64'd0);
            chk("empty_starts", 64'(starts - s0), 64'd1);
        end

        // Back-pressure: full final block held for 5 cycles
        m_ready = 1'b0;
        msg = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        model_msg();
        drive_msg(1'b1);
        m_ready = 1'b1;

        // Reset mid-message, then a fresh 1-byte message
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_block", block_out, 64'd0);
        chk("midrst_last", 64'(last_out), 64'd0);
        chk("midrst_start", 64'(start_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("release_start", 64'(start_out), 64'd0);
        chk("release_m_valid", 64'(m_valid), 64'd0);
        msg = '{8'hAA};
        model_msg();
        chk("model_aa_blk", expq[0].blk, 64'hAA00000000000000);
        chk("model_aa_lst", 64'(expq[0].lst), 64'h002);
        drive_msg(1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
